chunked_accumulator: RTL

//  Parametrised successor to the lab accumulator datapath. It accumulates the

---
 rtl/accum_pkg.sv | 10 +
 rtl/chunk_adder.sv | 12 +
 rtl/chunked_accumulator.sv | 117 +++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding and sizing helpers for the chunked accumulator
package accum_pkg;
  typedef enum logic [1:0] {IDLE, ADD, WRITE, HOLD} accum_state_t;
  function automatic int nchunk(input int w, input int c);
    return w / c;
  endfunction
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit add with carry in/out
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);
  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
endmodule

// File: rtl/chunked_accumulator.sv
// chunked_accumulator: one add/sub per Run press using a CHUNK-bit adder over NCHUNK cycles
module chunked_accumulator
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Clear,
  input  logic             Sub,
  input  logic             Sat_En,
  input  logic [WIDTH-1:0] A_In,
  output logic [WIDTH-1:0] Acc_Out,
  output logic             Carry_Out,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  if (WIDTH % CHUNK != 0) begin : g_width_chk
    $error("WIDTH must be a multiple of CHUNK");
  end
  accum_state_t state_q, state_d;
  logic run_q;
  logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d, psum_q, psum_d, res;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, sat_q, sat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CHUNK-1:0] s;
  logic co, ovf_w, wr;
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a_i   (acc_q[idx_q*CHUNK +: CHUNK]),
    .b_i   (b_q[idx_q*CHUNK +: CHUNK]),
    .cin_i (carry_q),
    .s_o   (s),
    .cout_o(co)
  );
  assign ovf_w = (acc_q[WIDTH-1] == b_q[WIDTH-1]) && (psum_q[WIDTH-1] != acc_q[WIDTH-1]);
  assign res = (ovf_w && sat_q) ? (acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : psum_q;
  // The result is presented during the Done cycle and registered at its end
  assign wr = (state_q == WRITE) && !Clear;
  assign Done = wr;
  assign Busy = (state_q == ADD) || (state_q == WRITE);
  assign Acc_Out = wr ? res : acc_q;
  assign Carry_Out = wr ? carry_q : cout_q;
  assign Overflow = wr ? ovf_w : ovf_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    b_d = b_q;
    psum_d = psum_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    sat_d = sat_q;
    idx_d = idx_q;
    if (Clear) begin
      acc_d = '0;
      cout_d = 1'b0;
      ovf_d = 1'b0;
      state_d = Run ? HOLD : IDLE;
    end else begin
      case (state_q)
        IDLE: if (Run && !run_q) begin
          b_d = Sub ? ~A_In : A_In;
          carry_d = Sub;
          sat_d = Sat_En;
          idx_d = '0;
          psum_d = '0;
          state_d = ADD;
        end
        ADD: begin
          psum_d[idx_q*CHUNK +: CHUNK] = s;
          carry_d = co;
          idx_d = idx_q + 1'b1;
          state_d = (idx_q == LAST) ? WRITE : ADD;
        end
        WRITE: begin
          acc_d = res;
          cout_d = carry_q;
          ovf_d = ovf_w;
          state_d = Run ? HOLD : IDLE;
        end
        HOLD: state_d = Run ? HOLD : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      run_q <= 1'b0;
      acc_q <= '0;
      b_q <= '0;
      psum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= Run;
      acc_q <= acc_d;
      b_q <= b_d;
      psum_q <= psum_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
      idx_q <= idx_d;
    end
  end
endmodule
